// File: rtl/mem_seq_master_pkg.sv
// Shared definitions for the SRAM fill/verify sequencer.
// Holds the run mode encodings, the FSM state codes and a helper that maps
// mode 11 onto write+read-check. The control block and the bench import it too.
package mem_seq_master_pkg;

    localparam logic [1:0] MODE_WR_RD = 2'b00;
    localparam logic [1:0] MODE_WR    = 2'b01;
    localparam logic [1:0] MODE_RD    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Mode 11 has no meaning of its own and behaves as write+read-check.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_WR_RD : m;
    endfunction

endpackage

// File: rtl/mem_seq_master_if.sv
// Valid/ready SRAM request port.
//   valid    : request valid (initiator)
//   wr_rd_en : 1 = write, 0 = read (initiator)
//   addr     : request address (initiator)
//   wdata    : write data (initiator)
//   ready    : memory accepts/completes the request this cycle (memory)
//   rdata    : read data, valid when valid && ready && !wr_rd_en (memory)
interface mem_seq_master_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid;
    logic                  wr_rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  ready;
    logic [WIDTH-1:0]      rdata;

    modport master (output valid, wr_rd_en, addr, wdata, input ready, rdata);
    modport slave  (input valid, wr_rd_en, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_seq_master_lfsr.sv
// Galois LFSR (shift right, XOR with POLY when the bit shifted out is 1).
//   clk_i  : clock
//   clr_i  : synchronous active-high reset, loads the seed
//   load_i : reload the seed
//   step_i : advance one position (load wins)
//   q_o    : current value
module mem_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] q_o
);
    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] SEED_NZ =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    always_ff @(posedge clk_i) begin
        if (clr_i || load_i)
            q_o <= SEED_NZ;
        else if (step_i)
            q_o <= (q_o >> 1) ^ (q_o[0] ? POLY : '0);
    end
endmodule

// File: rtl/mem_seq_master.sv
// SRAM fill/verify initiator: writes a burst of LFSR data over a programmable
// address range, then reads the same range back and counts mismatches.
//   clk_i, clr_i      : clock, synchronous active-high reset
//   start_i, mode_i   : run request (sampled in IDLE only) and run mode
//   start_addr_i      : first address; the range wraps modulo DEPTH
//   count_i           : locations to access, clamped to DEPTH
//   busy_o, done_o    : run in progress / one-cycle end-of-run pulse
//   err_o, err_cnt_o  : sticky mismatch flag and mismatch count of the last run
//   first_err_addr_o  : address of the first mismatch
//   timeout_o         : last run aborted because ready never came
//   mem               : valid/ready memory port (master side)
//
// state   | meaning
// ST_IDLE | waiting for start_i
// ST_WR   | issuing writes of LFSR data
// ST_RD   | issuing reads, comparing against the regenerated LFSR sequence
// ST_DONE | one-cycle done_o pulse, then back to idle
module mem_seq_master
    import mem_seq_master_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter int               ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] SEED       = 8'hA5,
    parameter logic [WIDTH-1:0] POLY       = 8'hB8,
    parameter int               TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  timeout_o,
    mem_seq_master_if.master      mem
);
    localparam int            CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    state_t                state_q, state_n;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] start_addr_q, addr_q, first_err_q;
    logic [CW-1:0]         count_q, remain_q, err_cnt_q, count_clamp;
    logic [TW-1:0]         wait_q;
    logic                  busy_q, err_q, timeout_q;
    logic [WIDTH-1:0]      lfsr_q;
    logic                  lfsr_load, lfsr_step;
    logic                  active, accept, last, expire;

    mem_lfsr #(.WIDTH(WIDTH), .SEED(SEED), .POLY(POLY)) u_lfsr (
        .clk_i  (clk_i),
        .clr_i  (clr_i),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .q_o    (lfsr_q)
    );

    assign count_clamp = (count_i > DEPTH_C) ? DEPTH_C : count_i;
    assign active      = (state_q == ST_WR) || (state_q == ST_RD);
    assign accept      = active && mem.ready;
    assign last        = accept && (remain_q == CW'(1));
    // Wait timer counts down while stalled; expiry is the stall cycle at zero.
    assign expire      = active && !mem.ready && (wait_q == '0);

    assign mem.valid        = active;
    assign mem.wr_rd_en     = (state_q == ST_WR);
    assign mem.addr         = addr_q;
    assign mem.wdata        = (state_q == ST_WR) ? lfsr_q : '0;
    assign busy_o           = busy_q;
    assign done_o           = (state_q == ST_DONE);
    assign err_o            = err_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign timeout_o        = timeout_q;

    always_ff @(posedge clk_i) begin
        if (clr_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    lfsr_load = 1'b1;
                    if (count_clamp == '0)
                        state_n = ST_DONE;
                    else if (norm_mode(mode_i) == MODE_RD)
                        state_n = ST_RD;
                    else
                        state_n = ST_WR;
                end
            end
            ST_WR: begin
                if (expire) begin
                    state_n = ST_DONE;
                end else if (accept) begin
                    lfsr_step = 1'b1;
                    if (last) begin
                        if (mode_q == MODE_WR) begin
                            state_n = ST_DONE;
                        end else begin
                            // Read-back regenerates the sequence from the seed.
                            state_n   = ST_RD;
                            lfsr_load = 1'b1;
                            lfsr_step = 1'b0;
                        end
                    end
                end
            end
            ST_RD: begin
                if (expire)
                    state_n = ST_DONE;
                else if (accept) begin
                    lfsr_step = 1'b1;
                    if (last)
                        state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mode_q       <= MODE_WR_RD;
            start_addr_q <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q       <= norm_mode(mode_i);
                        start_addr_q <= start_addr_i;
                        addr_q       <= start_addr_i;
                        count_q      <= count_clamp;
                        remain_q     <= count_clamp;
                        wait_q       <= WAIT_LOAD;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        err_cnt_q    <= '0;
                        first_err_q  <= '0;
                        timeout_q    <= 1'b0;
                    end
                end
                ST_WR, ST_RD: begin
                    if (accept) begin
                        wait_q   <= WAIT_LOAD;
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (state_q == ST_RD && mem.rdata != lfsr_q) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_q + 1'b1;
                            if (!err_q)
                                first_err_q <= addr_q;
                        end
                        if (state_q == ST_WR && last && mode_q != MODE_WR) begin
                            addr_q   <= start_addr_q;
                            remain_q <= count_q;
                        end
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_DONE: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
